hex_scan_ctrl: RTL and testbench

Time-multiplexing controller for a 4-digit common-anode seven-segment display that shares one hex-to-segment decoder across all digits. Holds a double-buffered 16-bit hex value plus four decimal points, scans the digits at a programmable rate with a guard interval against ghosting, and drives the shared decoder's `hex` and `dp` inputs together with the active-low anode enables. Sits between the system register or user logic and the segment decoder at the display pins.

---
 rtl/hex_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: time-multiplexed scan controller for a 4-digit common-anode
// seven-segment display that shares one hex-to-segment decoder.
// Holds a double-buffered 16-bit value plus four decimal points and scans
// the digits. Each digit slot starts with a dark guard interval.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   -> leading zero digits (nibble and dp both zero) stay dark
//   undefined -> all four digits light in their slot
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_OFF   | scan parked, all anodes off, cnt/idx held at 0
// S_GUARD | first GUARD cycles of a slot, all anodes off (anti-ghosting)
// S_ON    | remainder of the slot, anode idx driven low

module hex_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int GUARD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] hex_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [3:0]  hex,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD > 0) ? (GUARD - 1) : 0);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_GUARD = 2'd1,
    S_ON    = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic [19:0]   pend, pend_n;
  logic          pend_v, pend_v_n;
  logic [19:0]   act, act_n;
  logic          boundary;
  logic [3:0]    an_n;
  logic [3:0]    hex_n;
  logic          dp_n;
  logic [3:0]    dp_bits;

  // Next scan position: slot counter, digit index and frame boundary.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    boundary = 1'b0;
    if (!en) begin
      state_n = S_OFF;
      cnt_n   = '0;
      idx_n   = 2'd0;
    end else begin
      case (state)
        S_OFF: begin
          state_n = (GUARD == 0) ? S_ON : S_GUARD;
          cnt_n   = '0;
          idx_n   = 2'd0;
        end
        S_GUARD: begin
          cnt_n = cnt + 1'b1;
          if (cnt == GUARD_LAST) state_n = S_ON;
        end
        S_ON: begin
          if (cnt == DIV_LAST) begin
            cnt_n    = '0;
            idx_n    = idx + 2'd1;
            state_n  = (GUARD == 0) ? S_ON : S_GUARD;
            boundary = (idx == 2'd3);
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = S_OFF;
          cnt_n   = '0;
          idx_n   = 2'd0;
        end
      endcase
    end
  end

  // Double buffer: swap only at frame boundaries (or freely while parked);
  // a load on the swap edge stays pending for the following frame.
  always_comb begin
    act_n    = act;
    pend_n   = pend;
    pend_v_n = pend_v;
    if ((state == S_OFF || boundary) && pend_v) begin
      act_n    = pend;
      pend_v_n = 1'b0;
    end
    if (load) begin
      pend_n   = {dp_in, hex_in};
      pend_v_n = 1'b1;
    end
  end

  // Output decode from next-state values so outputs line up with the new state.
  always_comb begin
    an_n    = 4'b1111;
    hex_n   = hex;
    dp_n    = dp;
    dp_bits = act_n[19:16];
    if (state_n == S_ON) begin
      an_n = ~(4'b0001 << idx_n);
      case (idx_n)
        2'd0:    hex_n = act_n[3:0];
        2'd1:    hex_n = act_n[7:4];
        2'd2:    hex_n = act_n[11:8];
        default: hex_n = act_n[15:12];
      endcase
      dp_n = ~dp_bits[idx_n];
`ifdef LEADING_ZERO_BLANK_EN
      case (idx_n)
        2'd3: if (act_n[15:12] == 4'h0 && !act_n[19]) an_n = 4'b1111;
        2'd2: if (act_n[15:8] == 8'h00 && act_n[19:18] == 2'b00) an_n = 4'b1111;
        2'd1: if (act_n[15:4] == 12'h000 && act_n[19:17] == 3'b000) an_n = 4'b1111;
        default: ;
      endcase
`endif
    end
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_OFF;
      cnt        <= '0;
      idx        <= 2'd0;
      pend       <= '0;
      pend_v     <= 1'b0;
      act        <= '0;
      an         <= 4'b1111;
      hex        <= 4'h0;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      pend       <= pend_n;
      pend_v     <= pend_v_n;
      act        <= act_n;
      an         <= an_n;
      hex        <= hex_n;
      dp         <= dp_n;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl (DIV=8, GUARD=2). Expected outputs come from a
// timeline model: cycles since enable give slot position and digit directly.
module tb_hex_scan_ctrl;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        reset, en, load;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic [3:0]  an, hex;
  logic        dp, frame_tick;

  int checks = 0;
  int errors = 0;

  logic [9:0] expq[$];

  // model state
  logic        m_run = 1'b0;
  int          m_s = 0;
  logic [19:0] m_pend = '0, m_act = '0;
  logic        m_pv = 1'b0;
  logic [3:0]  m_hex = 4'h0;
  logic        m_dp = 1'b1;

  hex_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load),
    .hex_in(hex_in), .dp_in(dp_in),
    .an(an), .hex(hex), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Predict outputs after the coming edge from the inputs now applied.
  task automatic model_edge(input logic r, e, l, input logic [15:0] h, input logic [3:0] d);
    logic       old_run, bnd;
    logic [3:0] m_an;
    int         dig;
    bnd  = 1'b0;
    m_an = 4'b1111;
    if (r) begin
      m_run = 1'b0; m_s = 0; m_pend = '0; m_pv = 1'b0; m_act = '0;
      m_hex = 4'h0; m_dp = 1'b1;
    end else begin
      old_run = m_run;
      if (!e) m_run = 1'b0;
      else if (!m_run) begin m_run = 1'b1; m_s = 0; end
      else begin m_s = m_s + 1; bnd = ((m_s % FRAME) == 0); end
      if ((!old_run || bnd) && m_pv) begin m_act = m_pend; m_pv = 1'b0; end
      if (l) begin m_pend = {d, h}; m_pv = 1'b1; end
      if (m_run && (m_s % DIV) >= GUARD) begin
        dig   = (m_s / DIV) % 4;
        m_hex = 4'((m_act[15:0] >> (4 * dig)));
        m_dp  = ~m_act[16 + dig];
        m_an  = ~(4'b0001 << dig);
`ifdef LEADING_ZERO_BLANK_EN
        if (dig > 0 && (m_act[15:0] >> (4 * dig)) == 16'h0 && (m_act[19:16] >> dig) == 4'h0)
          m_an = 4'b1111;
`endif
      end
    end
    expq.push_back({m_an, m_hex, m_dp, bnd});
  endtask

  task automatic step(input logic r, e, l, input logic [15:0] h, input logic [3:0] d);
    reset = r; en = e; load = l; hex_in = h; dp_in = d;
    model_edge(r, e, l, h, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic e, input int n);
    for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 16'h0, 4'h0);
  endtask

  function automatic logic lit_digit(input int dg);
    return m_run && (m_s % DIV) >= GUARD && ((m_s / DIV) % 4) == dg;
  endfunction

  // Run enabled until the model says digit dg is lit.
  task automatic run_to_digit(input int dg, input string tag);
    for (int i = 0; i < 4 * FRAME && !lit_digit(dg); i++) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    if (!lit_digit(dg)) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for digit %0d", tag, dg);
    end
  endtask

  // Monitor: compare each DUT output cycle against the queued prediction.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        if ({an, hex, dp, frame_tick} !== e) begin
          errors++;
          $display("FAIL out t=%0t: an=%b hex=%h dp=%b ft=%b, want an=%b hex=%h dp=%b ft=%b",
                   $time, an, hex, dp, frame_tick, e[9:6], e[5:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    logic e_r;
    // reset with en held high, then free scan
    step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    idle(1'b1, 40);

    // scan order with 1234 / dp on digit 2
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 16'h1234, 4'b0100);
    idle(1'b0, 3);
    idle(1'b1, 2 * FRAME + 4);

    // tear-free update: load while digit 1 lit
    run_to_digit(1, "tearfree");
    step(1'b0, 1'b1, 1'b1, 16'hABCD, 4'b0001);
    idle(1'b1, FRAME + 8);

    // load on the frame-boundary edge with 1111 already pending
    run_to_digit(1, "bnd_pre");
    step(1'b0, 1'b1, 1'b1, 16'h1111, 4'h0);
    for (int i = 0; i < 2 * FRAME && ((m_s + 1) % FRAME) != 0; i++)
      step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 16'h5555, 4'b1000);
    idle(1'b1, 2 * FRAME + 2);

    // enable drop mid-slot on digit 2, then re-enable
    run_to_digit(2, "endrop");
    idle(1'b1, 1);
    idle(1'b0, 5);
    idle(1'b1, FRAME + 4);

    // leading-zero candidate value
    idle(1'b0, 1);
    step(1'b0, 1'b0, 1'b1, 16'h0007, 4'h0);
    idle(1'b0, 2);
    idle(1'b1, FRAME + 4);
    step(1'b0, 1'b1, 1'b1, 16'h0030, 4'b0100);
    idle(1'b1, 2 * FRAME);

    // randomized traffic
    e_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic r, l;
      if ($urandom_range(0, 59) == 0) e_r = ~e_r;
      r = ($urandom_range(0, 299) == 0);
      l = ($urandom_range(0, 14) == 0);
      step(r, e_r, l, 16'($urandom), 4'($urandom));
    end

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, want 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
